ar_access_arbiter: RTL

Round-robin arbiter and sequencer that shares the single 12-bit address register (AR) between NUM_REQ requesters (processor cores / DMA).
Grants one requester at a time and drives the AR's write_en, clr_en and datain.
Waits a fixed memory latency, acknowledges the requester, then clears AR.
Sits between the core request lines and the shared AR/memory port.

---
 rtl/ar_access_arbiter_if.sv | 44 ++++
 rtl/ar_access_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ar_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// ar_access_arbiter_if
// Purpose : bundles the requester-side lines and the shared address register
//           (AR) control lines of ar_access_arbiter.
// Signals :
//   req         requester -> arbiter, per-requester request level
//   addr_in     requester -> arbiter, packed addresses, lane i at [i*ADDR_W +: ADDR_W]
//   grant       arbiter -> requester, one-hot owner, zero when idle
//   ack         arbiter -> requester, one-cycle completion pulse to the owner
//   ar_write_en arbiter -> AR, load strobe
//   ar_clr_en   arbiter -> AR, clear strobe
//   ar_datain   arbiter -> AR, address to load
//   busy        arbiter status, high whenever a transaction is in flight
//
// Handshake: a requester raises req[i] (with its address on lane i) and holds
// it until it sees ack[i]; it must drop req[i] in the cycle after ack[i].
// The arbiter only samples req/addr_in while idle, so a request that stays
// high after its ack is simply a fresh request at lowest priority.
// ---------------------------------------------------------------------------
interface ar_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr_in;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        ack;
  logic                      ar_write_en;
  logic                      ar_clr_en;
  logic [ADDR_W-1:0]         ar_datain;
  logic                      busy;

  // Requester side (cores / DMA and the AR observer).
  modport master (
    output req, addr_in,
    input  grant, ack, ar_write_en, ar_clr_en, ar_datain, busy
  );

  // Arbiter side.
  modport slave (
    input  req, addr_in,
    output grant, ack, ar_write_en, ar_clr_en, ar_datain, busy
  );
endinterface

// File: rtl/ar_access_arbiter.sv
// ---------------------------------------------------------------------------
// ar_access_arbiter
// Purpose : round-robin arbiter/sequencer sharing one ADDR_W-bit address
//           register between NUM_REQ requesters. A transaction is
//           IDLE -> LOAD (AR write strobe) -> WAIT (MEM_LAT cycles)
//           -> ACK (ack pulse + AR clear strobe) -> IDLE.
// Ports   :
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   bus      ar_access_arbiter_if.slave (req/addr_in in, grant/ack/AR/busy out)
//   state_o  current FSM state (debug visibility)
// All outputs are registered.
// ---------------------------------------------------------------------------
module ar_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ar_access_arbiter_if.slave   bus,
  output logic [1:0]           state_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [3:0]         cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               we_q;
  logic               clr_q;
  logic [ADDR_W-1:0]  datain_q;

  // Unpacked view of the address lanes so the selected lane can be indexed.
  logic [ADDR_W-1:0]  addr_lane [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign addr_lane[g] = bus.addr_in[g*ADDR_W +: ADDR_W];
  end

  // Round-robin pick: first set request at or after ptr_q, wrapping.
  logic               sel_valid_d;
  logic [PTR_W-1:0]   sel_idx_d;
  logic [PTR_W:0]     sum_d;

  always_comb begin
    sel_valid_d = 1'b0;
    sel_idx_d   = '0;
    sum_d       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_d = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum_d >= (PTR_W+1)'(NUM_REQ)) begin
        sum_d = sum_d - (PTR_W+1)'(NUM_REQ);
      end
      if (!sel_valid_d && bus.req[sum_d[PTR_W-1:0]]) begin
        sel_valid_d = 1'b1;
        sel_idx_d   = sum_d[PTR_W-1:0];
      end
    end
  end

  logic [PTR_W-1:0] ptr_next_d;
  assign ptr_next_d = (owner_q == PTR_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      we_q     <= 1'b0;
      clr_q    <= 1'b0;
      datain_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid_d) begin
            state_q  <= LOAD;
            owner_q  <= sel_idx_d;
            grant_q  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_d;
            datain_q <= addr_lane[sel_idx_d];
            we_q     <= 1'b1;
          end
        end
        LOAD: begin
          we_q  <= 1'b0;
          cnt_q <= LAT;
          if (MEM_LAT == 0) begin
            state_q <= ACK;
            ack_q   <= grant_q;
            clr_q   <= 1'b1;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // cnt_q enters at MEM_LAT; the last WAIT cycle sees 1.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= ACK;
            ack_q   <= grant_q;
            clr_q   <= 1'b1;
          end
        end
        ACK: begin
          state_q  <= IDLE;
          ack_q    <= '0;
          clr_q    <= 1'b0;
          grant_q  <= '0;
          datain_q <= '0;
          ptr_q    <= ptr_next_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.ack         = ack_q;
  assign bus.ar_write_en = we_q;
  assign bus.ar_clr_en   = clr_q;
  assign bus.ar_datain   = datain_q;
  assign bus.busy        = (state_q != IDLE);
  assign state_o         = state_q;

endmodule
